// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Receive side of the VGA timing generator. Samples hsync/vsync/blank_b on
// the pixel clock, rebuilds the pixel coordinates, checks line length,
// frame height and blank alignment, and reports lock and sticky errors.
// Every output is registered and describes the input sample taken one
// clock earlier.
module vga_sync_decoder #(
  parameter int HACTIVE = 640,
  parameter int HFP     = 16,
  parameter int HSYNC   = 96,
  parameter int HBP     = 48,
  parameter int VACTIVE = 480,
  parameter int VFP     = 10,
  parameter int VSYNC   = 2,
  parameter int VBP     = 33
) (
  input  logic       vgaclk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       blank_b,
  input  logic       clr_err,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pixel_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic       blank_err
);

  localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;

  localparam logic [9:0] H_LAST  = 10'(HTOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(VTOTAL - 1);
  localparam logic [9:0] H_LO    = 10'(HSYNC + HBP);
  localparam logic [9:0] H_HI    = 10'(HSYNC + HBP + HACTIVE);
  localparam logic [9:0] V_LO    = 10'(VSYNC + VBP);
  localparam logic [9:0] V_HI    = 10'(VSYNC + VBP + VACTIVE);
  localparam logic [9:0] CNT_MAX = 10'h3ff;

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // Sampled inputs and edge detection
  logic       hs_q, vs_q, bl_q;
  logic       hfall, vfall, frame_rst;
  logic       bad_line, bad_frame;

  // Position counters
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       vpend_q, vpend_d;

  // Lock state machine
  logic [1:0] state_q, state_d;

  // Registered outputs
  logic       locked_q, locked_d;
  logic       win_q, win_d;
  logic       pv_q, pv_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       ls_q, fs_q;
  logic       h_err_q, h_err_d;
  logic       v_err_q, v_err_d;
  logic       be_q, be_d;

  function automatic logic in_window(input logic [9:0] h, input logic [9:0] v);
    return (h >= H_LO) && (h < H_HI) && (v >= V_LO) && (v < V_HI);
  endfunction

  // A frame boundary is the first hsync fall at or after a vsync fall; a
  // vsync fall landing on the same clock as the hsync fall counts directly.
  assign hfall     = hs_q & ~hsync;
  assign vfall     = vs_q & ~vsync;
  assign frame_rst = hfall & (vpend_q | vfall);
  assign bad_line  = hfall & (hcnt_q != H_LAST);
  assign bad_frame = frame_rst & (vcnt_q != V_LAST);

  // Next-state for the saturating position counters and the pending-vsync flag
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    hcnt_d  = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1;
    vcnt_d  = vcnt_q;
    vpend_d = vpend_q | vfall;
    if (hfall) begin
      hcnt_d = '0;
      if (frame_rst) begin
        vcnt_d  = '0;
        vpend_d = 1'b0;
      end else if (vcnt_q != CNT_MAX) begin
        vcnt_d = vcnt_q + 10'd1;
      end
    end
  end

  // Lock FSM: align on a frame boundary, measure one frame, then hold lock
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (frame_rst) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (bad_line || bad_frame) state_d = ST_SEARCH;
        else if (frame_rst)        state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (bad_line || bad_frame) state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Next values of the registered outputs and the sticky error flags
  always_comb begin
    // locked follows the FSM one clock late, and pixel_valid uses the same
    // term so that pixel_valid == locked && window in every cycle.
    locked_d = (state_q == ST_LOCKED);
    win_d    = in_window(hcnt_d, vcnt_d);
    pv_d     = locked_d & win_d;
    x_d      = pv_d ? hcnt_d - H_LO : '0;
    y_d      = pv_d ? vcnt_d - V_LO : '0;
    // A new error beats a clear arriving on the same clock.
    h_err_d  = ((state_q == ST_LOCKED) & bad_line)  | (h_err_q & ~clr_err);
    v_err_d  = ((state_q == ST_LOCKED) & bad_frame) | (v_err_q & ~clr_err);
    be_d     = (locked_q & (bl_q != win_q))          | (be_q & ~clr_err);
  end

  // Input sampling and position counters
  always_ff @(posedge vgaclk or negedge reset) begin
    if (!reset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      bl_q    <= 1'b0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      vpend_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register sees the pre-edge value of every other register.
      hs_q    <= hsync;
      vs_q    <= vsync;
      bl_q    <= blank_b;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      vpend_q <= vpend_d;
    end
  end

  // Lock FSM state register
  always_ff @(posedge vgaclk or negedge reset) begin
    if (!reset) state_q <= ST_SEARCH;
    else        state_q <= state_d;
  end

  // Output and error-flag registers
  always_ff @(posedge vgaclk or negedge reset) begin
    if (!reset) begin
      locked_q <= 1'b0;
      win_q    <= 1'b0;
      pv_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      h_err_q  <= 1'b0;
      v_err_q  <= 1'b0;
      be_q     <= 1'b0;
    end else begin
      locked_q <= locked_d;
      win_q    <= win_d;
      pv_q     <= pv_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ls_q     <= hfall;
      fs_q     <= frame_rst;
      h_err_q  <= h_err_d;
      v_err_q  <= v_err_d;
      be_q     <= be_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pixel_valid = pv_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign blank_err   = be_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
// Drives a sync-first VGA stream (hsync low at the start of each line,
// vsync low for the first lines of a frame) into the decoder. Expected
// output values are queued when a pixel is driven and compared one clock
// later, when the decoder reports that pixel.
module tb_vga_sync_decoder;

  // Scaled-down timing so one frame is a few hundred clocks.
  localparam int TB_HA  = 16;
  localparam int TB_HFP = 4;
  localparam int TB_HS  = 6;
  localparam int TB_HBP = 4;
  localparam int TB_VA  = 12;
  localparam int TB_VFP = 2;
  localparam int TB_VS  = 2;
  localparam int TB_VBP = 3;

  localparam int HT  = TB_HA + TB_HFP + TB_HS + TB_HBP;
  localparam int VT  = TB_VA + TB_VFP + TB_VS + TB_VBP;
  localparam int HW0 = TB_HS + TB_HBP;
  localparam int VW0 = TB_VS + TB_VBP;
  localparam int HL  = HW0 + TB_HA - 1;
  localparam int VL  = VW0 + TB_VA - 1;

  localparam logic [26:0] M_X  = {10'h3ff, 17'd0};
  localparam logic [26:0] M_Y  = {10'd0, 10'h3ff, 7'd0};
  localparam logic [26:0] M_PV = 27'd64;
  localparam logic [26:0] M_LS = 27'd32;
  localparam logic [26:0] M_FS = 27'd16;
  localparam logic [26:0] M_LK = 27'd8;
  localparam logic [26:0] M_HE = 27'd4;
  localparam logic [26:0] M_VE = 27'd2;
  localparam logic [26:0] M_BE = 27'd1;

  typedef struct {
    string       tag;
    logic [26:0] exp;
    logic [26:0] mask;
  } sb_t;

  logic       vgaclk = 1'b0;
  logic       reset;
  logic       hsync, vsync, blank_b, clr_err;
  logic [9:0] x, y;
  logic       pixel_valid, line_start, frame_start, locked;
  logic       h_err, v_err, blank_err;
  logic [26:0] obs;

  sb_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  exp_he = 1'b0;
  bit  exp_ve = 1'b0;
  bit  exp_be = 1'b0;

  vga_sync_decoder #(
    .HACTIVE(TB_HA), .HFP(TB_HFP), .HSYNC(TB_HS), .HBP(TB_HBP),
    .VACTIVE(TB_VA), .VFP(TB_VFP), .VSYNC(TB_VS), .VBP(TB_VBP)
  ) dut (
    .vgaclk      (vgaclk),
    .reset       (reset),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_b     (blank_b),
    .clr_err     (clr_err),
    .x           (x),
    .y           (y),
    .pixel_valid (pixel_valid),
    .line_start  (line_start),
    .frame_start (frame_start),
    .locked      (locked),
    .h_err       (h_err),
    .v_err       (v_err),
    .blank_err   (blank_err)
  );

  always #5 vgaclk = ~vgaclk;

  assign obs = {x, y, pixel_valid, line_start, frame_start, locked, h_err, v_err, blank_err};

  function automatic logic [26:0] mk(input int xv, input int yv, input logic pv,
                                     input logic ls, input logic fs, input logic lk,
                                     input logic he, input logic ve, input logic be);
    logic [9:0] xs, ys;
    xs = 10'(xv);
    ys = 10'(yv);
    return {xs, ys, pv, ls, fs, lk, he, ve, be};
  endfunction

  task automatic check(input string tag, input logic [26:0] o, input logic [26:0] e,
                       input logic [26:0] m);
    n_vec++;
    assert ((o & m) === (e & m))
    else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h (mask %h)", tag, o & m, e & m, m);
    end
  endtask

  task automatic push(input string tag, input logic [26:0] e, input logic [26:0] m);
    sb_t s;
    s.tag  = tag;
    s.exp  = e;
    s.mask = m;
    sb.push_back(s);
  endtask

  // One pixel: compare the result of the previous pixel, then drive this one.
  task automatic drive(input logic hs_v, input logic vs_v, input logic bl_v, input logic clr_v);
    sb_t s;
    @(negedge vgaclk);
    if (sb.size() != 0) begin
      s = sb.pop_front();
      check(s.tag, obs, s.exp, s.mask);
    end
    hsync   = hs_v;
    vsync   = vs_v;
    blank_b = bl_v;
    clr_err = clr_v;
  endtask

  // mode: 0 unlocked all frame, 1 locked all frame,
  //       2 lock rises at the frame start, 3 lock drops at the frame start
  //       after a bad frame height.
  task automatic run_frame(input int mode, input int nlines, input int short_line,
                           input int clr_line, input bit hole, input int rst_line,
                           input bit early);
    bit   lk_now;
    int   hlen;
    logic hs_v, vs_v, bl_v, clr_v;
    lk_now = (mode == 1) || (mode == 3);
    for (int v = 0; v < nlines; v++) begin
      hlen = (v == short_line) ? HT - 1 : HT;
      for (int h = 0; h < hlen; h++) begin
        hs_v  = (h >= TB_HS);
        vs_v  = !((v < TB_VS) || (early && v == nlines - 1 && h >= HT / 2));
        bl_v  = (h >= HW0) && (h < HW0 + TB_HA) && (v >= VW0) && (v < VW0 + TB_VA);
        if (hole && v == VW0 + 3 && h == HW0 + 5) bl_v = 1'b0;
        clr_v = (v == clr_line) && (h == 2);
        drive(hs_v, vs_v, bl_v, clr_v);
        if (v == rst_line && h == 23) reset = 1'b1;

        if (v == 0 && h == 0 && mode == 3) exp_ve = 1'b1;
        if (v == 0 && h == 1 && mode == 2) lk_now = 1'b1;
        if (v == 0 && h == 1 && mode == 3) lk_now = 1'b0;
        if (short_line >= 0 && v == short_line + 1 && h == 0) exp_he = 1'b1;
        if (short_line >= 0 && v == short_line + 1 && h == 1) lk_now = 1'b0;
        if (clr_v) begin
          exp_he = 1'b0;
          exp_ve = 1'b0;
        end
        if (hole && v == VW0 + 3 && h == HW0 + 8) exp_be = 1'b1;

        if (v == 0 && h == 0)
          push("frame_start", mk(0, 0, 0, 1, 1, lk_now, exp_he, exp_ve, 0),
               M_LS | M_FS | M_LK | M_HE | M_VE);
        if (v == 0 && h == 1)
          push("pulse_end", mk(0, 0, 0, 0, 0, lk_now, 0, 0, 0), M_LS | M_FS | M_LK);
        if (v == 1 && h == 0)
          push("line_start", mk(0, 0, 0, 1, 0, 0, 0, 0, 0), M_LS | M_FS);
        if (v == VW0 && h == HW0 - 1)
          push("pre_window", mk(0, 0, 0, 0, 0, lk_now, 0, 0, 0), M_X | M_Y | M_PV | M_LK);
        if (v == VW0 && h == HW0)
          push("first_pixel", mk(0, 0, lk_now, 0, 0, lk_now, 0, 0, 0), M_X | M_Y | M_PV | M_LK);
        if (v == VW0 + 2 && h == HW0 + 3)
          push("mid_pixel", mk(lk_now ? 3 : 0, lk_now ? 2 : 0, lk_now, 0, 0, lk_now,
                               exp_he, exp_ve, exp_be),
               M_X | M_Y | M_PV | M_LK | M_HE | M_VE | M_BE);
        if (v == VL && h == HL)
          push("last_pixel", mk(lk_now ? TB_HA - 1 : 0, lk_now ? TB_VA - 1 : 0, lk_now,
                                0, 0, lk_now, 0, 0, 0), M_X | M_Y | M_PV | M_LK);
        if (v == VL && h == HL + 1)
          push("post_window", mk(0, 0, 0, 0, 0, lk_now, 0, 0, 0), M_X | M_Y | M_PV | M_LK);
        if (short_line >= 0 && v == short_line + 1 && (h == 0 || h == 1))
          push("short_line", mk(0, 0, 0, 0, 0, lk_now, exp_he, 0, 0), M_LK | M_HE);
        if (v == clr_line && (h == 1 || h == 2))
          push("err_clear", mk(0, 0, 0, 0, 0, 0, exp_he, exp_ve, 0), M_HE | M_VE);
        if (hole && v == VW0 + 3 && (h == HW0 + 5 || h == HW0 + 8))
          push("blank_hole", mk(h - HW0, 3, 1, 0, 0, 1, 0, 0, exp_be),
               M_X | M_Y | M_PV | M_LK | ((h == HW0 + 8) ? M_BE : 27'd0));

        if (v == rst_line && h == 20) begin
          #1 reset = 1'b0;
          #1 check("reset_mid_frame", obs, 27'd0, '1);
          exp_he = 1'b0;
          exp_ve = 1'b0;
          exp_be = 1'b0;
          lk_now = 1'b0;
        end
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    hsync   = 1'b1;
    vsync   = 1'b1;
    blank_b = 1'b0;
    clr_err = 1'b0;

    // Reset held with random inputs: every output stays 0.
    for (int i = 0; i < 8; i++) begin
      @(negedge vgaclk);
      check("reset_hold", obs, 27'd0, '1);
      hsync   = 1'($urandom_range(0, 1));
      vsync   = 1'($urandom_range(0, 1));
      blank_b = 1'($urandom_range(0, 1));
      clr_err = 1'($urandom_range(0, 1));
    end
    @(negedge vgaclk);
    hsync   = 1'b1;
    vsync   = 1'b1;
    blank_b = 1'b0;
    clr_err = 1'b0;
    reset   = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);

    // Acquire lock on a clean stream.
    run_frame(0, VT, -1, -1, 1'b0, -1, 1'b0);
    run_frame(2, VT, -1, -1, 1'b0, -1, 1'b0);
    // One line a clock short while locked, then relock.
    run_frame(1, VT, 8, -1, 1'b0, -1, 1'b0);
    run_frame(0, VT, -1, -1, 1'b0, -1, 1'b0);
    run_frame(2, VT, -1, -1, 1'b0, -1, 1'b0);
    // One frame a line short while locked, then clear the errors.
    run_frame(1, VT - 1, -1, -1, 1'b0, -1, 1'b0);
    run_frame(3, VT, -1, 10, 1'b0, -1, 1'b0);
    run_frame(0, VT, -1, -1, 1'b0, -1, 1'b0);
    // Blank dropped for one visible pixel while locked.
    run_frame(2, VT, -1, -1, 1'b1, -1, 1'b0);
    // Reset mid-frame, then relock; vsync falls mid-line before the lock frame.
    run_frame(1, VT, -1, -1, 1'b0, 11, 1'b0);
    run_frame(0, VT, -1, -1, 1'b0, -1, 1'b1);
    run_frame(2, VT, -1, -1, 1'b0, -1, 1'b0);

    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
